// File: rtl/pe_result_collector.sv
// pe_result_collector: gathers the 34-bit P stream from the last FIOS processing element.
// Each valid partial result is added to the running carry. The low 17 bits are stored as one
// result word and the upper bits carry into the next word. Once S words are packed, the result
// is offered to the consumer through a valid/ready handshake.
module pe_result_collector #(
    parameter int unsigned S = 16,
    localparam int unsigned CNT_W = (S > 1) ? $clog2(S) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              valid_i,
    input  logic [33:0]       P_i,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [S*17-1:0]   res_o,
    output logic              overflow_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(S - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StOut} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [17:0]       carry_q;
    logic [S*17-1:0]   res_q;
    logic              res_valid_q;
    logic              overflow_q;
    logic [34:0]       sum;

    // Incoming partial result plus the carry left over from the previous word.
    always_comb begin
        sum = {1'b0, P_i} + {17'b0, carry_q};
    end

    // Collector FSM: word packing, carry propagation and the result handshake.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            carry_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCollect;
                        count_q <= '0;
                        carry_q <= '0;
                    end
                end
                StCollect: begin
                    if (valid_i) begin
                        res_q[32'(count_q) * 17 +: 17] <= sum[16:0];
                        carry_q                        <= sum[34:17];
                        if (count_q == LastCnt) begin
                            // Last word: present the result on the next cycle.
                            count_q     <= '0;
                            state_q     <= StOut;
                            res_valid_q <= 1'b1;
                            overflow_q  <= (sum[34:17] != 18'd0);
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        if (start_i) begin
                            // Back-to-back operation: skip IDLE.
                            state_q <= StCollect;
                            count_q <= '0;
                            carry_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Busy is decoded from the state; the other outputs come straight from registers.
    always_comb begin
        busy_o      = (state_q != StIdle);
        res_valid_o = res_valid_q;
        res_o       = res_q;
        overflow_o  = overflow_q;
    end

endmodule
